// File: rtl/bsg_comm_link_credit_tx.sv
// Transmit end of one comm-link channel: registers guts words onto the pins
// and tracks remote receive-FIFO credits, which come back as toggles on the token line.
module bsg_comm_link_credit_tx #(
  parameter int width_p                = 9,
  parameter int credits_p              = 16,
  parameter int lg_credit_decimation_p = 2
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               v_i,
  input  logic [width_p-1:0]                 data_i,
  output logic                               ready_o,
  output logic                               io_v_o,
  output logic [width_p-1:0]                 io_data_o,
  input  logic                               io_tkn_i,
  output logic [$clog2(credits_p+1)-1:0]     credit_o,
  output logic                               idle_o,
  output logic                               error_o
);

  localparam int credit_width_lp = $clog2(credits_p+1);
  localparam logic [credit_width_lp:0]   credits_max_lp   = (credit_width_lp+1)'(credits_p);
  localparam logic [credit_width_lp:0]   credit_return_lp = (credit_width_lp+1)'(1 << lg_credit_decimation_p);
  localparam logic [credit_width_lp-1:0] credits_init_lp  = credit_width_lp'(credits_p);

  logic [credit_width_lp-1:0] credit_r;
  logic                       tkn_r;
  logic                       error_r;
  logic                       io_v_r;
  logic [width_p-1:0]         io_data_r;

  logic                       ready_s;
  logic                       send_s;
  logic                       return_s;
  logic                       overflow_s;
  logic [credit_width_lp:0]   credit_dec_s;
  logic [credit_width_lp:0]   credit_sum_s;
  logic [credit_width_lp-1:0] credit_next_s;

  // ready comes only from the credit register, so guts never see a v_i -> ready loop
  assign ready_s  = (credit_r != {credit_width_lp{1'b0}});
  assign send_s   = v_i & ready_s;
  assign return_s = io_tkn_i ^ tkn_r;

  // Credit arithmetic one bit wider than the counter so overflow shows before saturating
  always_comb begin
    credit_dec_s = {1'b0, credit_r} - {{credit_width_lp{1'b0}}, send_s};
    if (return_s) begin
      credit_sum_s = credit_dec_s + credit_return_lp;
    end else begin
      credit_sum_s = credit_dec_s;
    end
    if (credit_sum_s > credits_max_lp) begin
      credit_next_s = credits_init_lp;
      overflow_s    = 1'b1;
    end else begin
      credit_next_s = credit_sum_s[credit_width_lp-1:0];
      overflow_s    = 1'b0;
    end
  end

  // Credit counter, token history, sticky overflow flag and channel valid
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credit_r <= credits_init_lp;
      tkn_r    <= 1'b0;
      error_r  <= 1'b0;
      io_v_r   <= 1'b0;
    end else begin
      credit_r <= credit_next_s;
      tkn_r    <= io_tkn_i;
      error_r  <= error_r | overflow_s;
      io_v_r   <= send_s;
    end
  end

  // Channel data loads only on an accepted word and otherwise holds
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      io_data_r <= {width_p{1'b0}};
    end else if (send_s) begin
      io_data_r <= data_i;
    end else begin
      io_data_r <= io_data_r;
    end
  end

  assign ready_o   = ready_s;
  assign io_v_o    = io_v_r;
  assign io_data_o = io_data_r;
  assign credit_o  = credit_r;
  assign idle_o    = (credit_r == credits_init_lp);
  assign error_o   = error_r;

endmodule

// File: tb/tb_bsg_comm_link_credit_tx.sv
// Scoreboard bench for bsg_comm_link_credit_tx: directed credit scenarios,
// then random traffic against a remote token-return model.
module tb_bsg_comm_link_credit_tx;

  logic       clk;
  logic       reset_i;
  logic       v_i;
  logic [8:0] data_i;
  logic       ready_o;
  logic       io_v_o;
  logic [8:0] io_data_o;
  logic       io_tkn_i;
  logic [4:0] credit_o;
  logic       idle_o;
  logic       error_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model state
  int         m_credit;
  logic       m_tkn;
  logic       m_err;
  logic [8:0] m_data;
  logic       m_send;
  logic [8:0] sb_q[$];

  bsg_comm_link_credit_tx #(
    .width_p(9),
    .credits_p(16),
    .lg_credit_decimation_p(2)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .v_i(v_i),
    .data_i(data_i),
    .ready_o(ready_o),
    .io_v_o(io_v_o),
    .io_data_o(io_data_o),
    .io_tkn_i(io_tkn_i),
    .credit_o(credit_o),
    .idle_o(idle_o),
    .error_o(error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // drive one cycle, advance the model, then check outputs after the edge
  task automatic cycle(input logic v, input logic [8:0] d, input logic tkn, input logic rst);
    logic exp_v;
    logic ret;
    int   sum;
    logic [8:0] w;
    v_i = v; data_i = d; io_tkn_i = tkn; reset_i = rst;
    check_value("ready", {31'd0, ready_o}, (m_credit != 0) ? 32'd1 : 32'd0);
    m_send = 1'b0;
    if (rst) begin
      m_credit = 16; m_tkn = 1'b0; m_err = 1'b0; m_data = 9'd0; exp_v = 1'b0;
    end else begin
      m_send = v && (m_credit != 0);
      ret    = (tkn != m_tkn);
      sum    = m_credit - (m_send ? 1 : 0) + (ret ? 4 : 0);
      if (sum > 16) begin
        m_credit = 16; m_err = 1'b1;
      end else begin
        m_credit = sum;
      end
      m_tkn = tkn;
      exp_v = m_send;
      if (m_send) begin
        sb_q.push_back(d);
        m_data = d;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_value("io_v", {31'd0, io_v_o}, {31'd0, exp_v});
    if (io_v_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_value("sb_unexpected_word", {23'd0, io_data_o}, 32'hffffffff);
      end else begin
        w = sb_q.pop_front();
        check_value("sb_data", {23'd0, io_data_o}, {23'd0, w});
      end
    end
    check_value("io_data_hold", {23'd0, io_data_o}, {23'd0, m_data});
    check_value("credit", {27'd0, credit_o}, m_credit);
    check_value("idle", {31'd0, idle_o}, (m_credit == 16) ? 32'd1 : 32'd0);
    check_value("error", {31'd0, error_o}, {31'd0, m_err});
  endtask

  initial begin
    int unsigned due_q[$];
    logic rtkn;
    int   sent;
    int   rcv;
    int   budget;

    m_credit = 16; m_tkn = 1'b0; m_err = 1'b0; m_data = 9'd0; m_send = 1'b0;
    reset_i = 1'b1; v_i = 1'b0; data_i = 9'd0; io_tkn_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // reset state
    cycle(1'b0, 9'd0, 1'b0, 1'b1);
    check_value("rst_credit", {27'd0, credit_o}, 32'd16);
    check_value("rst_idle", {31'd0, idle_o}, 32'd1);

    // drain all 16 credits with data 0..15
    for (int i = 0; i < 16; i++) cycle(1'b1, 9'(i), 1'b0, 1'b0);
    check_value("drain_credit", {27'd0, credit_o}, 32'd0);
    check_value("drain_ready", {31'd0, ready_o}, 32'd0);
    check_value("drain_idle", {31'd0, idle_o}, 32'd0);
    cycle(1'b1, 9'd99, 1'b0, 1'b0);

    // one toggle at credit 0 returns exactly 4 words
    cycle(1'b1, 9'd100, 1'b1, 1'b0);
    check_value("tkn_credit4", {27'd0, credit_o}, 32'd4);
    for (int i = 0; i < 5; i++) cycle(1'b1, 9'(101 + i), 1'b1, 1'b0);
    check_value("tkn_exhaust_ready", {31'd0, ready_o}, 32'd0);

    // reach 5, then send with a simultaneous return
    cycle(1'b0, 9'd0, 1'b0, 1'b0);
    cycle(1'b0, 9'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 9'(150 + i), 1'b1, 1'b0);
    check_value("pre_simul_credit", {27'd0, credit_o}, 32'd5);
    cycle(1'b1, 9'd200, 1'b0, 1'b0);
    check_value("simul_credit", {27'd0, credit_o}, 32'd8);
    check_value("simul_data", {23'd0, io_data_o}, 32'd200);

    // reach exactly 16 without error, drop to 14, then overflow
    cycle(1'b0, 9'd0, 1'b1, 1'b0);
    cycle(1'b0, 9'd0, 1'b0, 1'b0);
    check_value("full_no_error", {31'd0, error_o}, 32'd0);
    cycle(1'b1, 9'd210, 1'b0, 1'b0);
    cycle(1'b1, 9'd211, 1'b0, 1'b0);
    cycle(1'b0, 9'd0, 1'b1, 1'b0);
    check_value("ovf_credit", {27'd0, credit_o}, 32'd16);
    check_value("ovf_error", {31'd0, error_o}, 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 9'(220 + i), 1'b1, 1'b0);
    check_value("ovf_sticky", {31'd0, error_o}, 32'd1);
    cycle(1'b0, 9'd0, 1'b0, 1'b1);
    check_value("ovf_rst_error", {31'd0, error_o}, 32'd0);
    check_value("ovf_rst_idle", {31'd0, idle_o}, 32'd1);

    // mid-stream reset at credit 3 drops the word presented during reset
    for (int i = 0; i < 13; i++) cycle(1'b1, 9'(280 + i), 1'b0, 1'b0);
    check_value("mid_credit3", {27'd0, credit_o}, 32'd3);
    cycle(1'b1, 9'd300, 1'b0, 1'b1);
    check_value("mid_rst_v", {31'd0, io_v_o}, 32'd0);
    check_value("mid_rst_data", {23'd0, io_data_o}, 32'd0);
    check_value("mid_rst_credit", {27'd0, credit_o}, 32'd16);
    for (int i = 0; i < 3; i++) cycle(1'b1, 9'(301 + i), 1'b0, 1'b0);
    check_value("resume_credit", {27'd0, credit_o}, 32'd13);
    cycle(1'b0, 9'd0, 1'b0, 1'b1);

    // random traffic with a remote that toggles once per 4 words received
    rtkn = 1'b0; sent = 0; rcv = 0; budget = 0;
    while (!(sent >= 10000 && rcv >= sent && due_q.size() == 0) && budget < 80000) begin
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        rtkn = ~rtkn;
        void'(due_q.pop_front());
      end
      cycle((sent < 10000) && ($urandom_range(0, 3) != 0), 9'($urandom_range(0, 511)), rtkn, 1'b0);
      if (m_send) sent++;
      if (io_v_o === 1'b1) begin
        rcv++;
        if (rcv % 4 == 0) due_q.push_back(cyc + $urandom_range(0, 10));
      end
      budget++;
    end
    check_value("rand_timeout", (budget < 80000) ? 32'd1 : 32'd0, 32'd1);
    check_value("rand_words_rcv", rcv, 32'd10000);
    check_value("rand_sb_empty", sb_q.size(), 32'd0);
    check_value("rand_final_credit", {27'd0, credit_o}, 32'd16);
    check_value("rand_final_error", {31'd0, error_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
